class_argmax_ctrl: RTL and testbench
====================================

// Module: class_argmax_ctrl
// PURPOSE
//   Sequencer for the final classification stage. Accepts one class score per beat from the
//   FC-output stream, buffers a frame of N_CLASSES scores, then runs a one-compare-per-cycle
//   argmax scan. Presents {max, index} on a valid/ready result port.
//   Sits between the fully-connected layer output and the result/readout logic.
// PARAMETERS
//   DATA_WIDTH  16                      score width; signed two's complement fixed-point
//   N_CLASSES   10                      scores per frame (>=1)
//   IDX_WIDTH   $clog2(N_CLASSES)       width of class index (>=1)
// PORTS
//   clk        in   1           clock, rising edge
//   rst_n      in   1           asynchronous active-low reset
//   clear      in   1           synchronous abort: drop current frame/result
//   s_valid    in   1           score beat valid
//   s_ready    out  1           controller can accept a score beat
//   s_data     in   DATA_WIDTH  class score (signed)
//   s_last     in   1           final beat of frame
//   m_valid    out  1           result valid
//   m_ready    in   1           result consumer ready
//   m_max      out  DATA_WIDTH  maximum score of frame
//   m_index    out  IDX_WIDTH   class index of m_max
//   m_err      out  1           frame length != N_CLASSES
//   busy       out  1           high in SCAN or OUT
// BEHAVIOUR
//   Reset (rst_n=0, async): state=COLLECT, beat count=0, s_ready=0 while in reset,
//     m_valid=0, m_max=0, m_index=0, m_err=0, busy=0. Score buffer contents don't care.
//   FSM COLLECT -> SCAN -> OUT -> COLLECT:
//     COLLECT: s_ready=1. Beat accepted on s_valid&&s_ready; stored at buf[cnt], cnt++.
//       Frame ends on the first accepted beat with s_last=1, or on beat N_CLASSES-1,
//       whichever comes first. Frame length L = cnt+1.
//       m_err=1 if s_last arrived before beat N_CLASSES-1, or if beat N_CLASSES-1 had s_last=0.
//       Frame-end edge: best<=buf[0] (or the beat itself if L=1), best_idx<=0, ptr<=1.
//       Go to SCAN if L>1, else OUT.
//     SCAN: s_ready=0, busy=1. Each cycle: if $signed(buf[ptr]) > $signed(best) then
//       best<=buf[ptr], best_idx<=ptr. Then ptr++. After ptr==L-1 is compared -> OUT.
//     OUT: m_valid=1, m_max=best, m_index=best_idx. m_err held.
//       All outputs stable while m_ready=0. On m_valid&&m_ready -> COLLECT, cnt=0.
//       m_valid drops and s_ready rises the next cycle.
//   Latency: m_valid rises L-1 cycles after the frame-end acceptance edge (9 for L=10).
//   Ties: strict '>' so the lowest index wins. Compare is signed; no saturation or widening.
//   clear=1 (any state): next edge -> COLLECT, cnt=0, m_valid=0, m_err=0.
//     clear has priority over a simultaneous s beat (beat dropped) or m handshake.
//   rst_n asserted mid-frame/scan: outputs clear immediately; partial frame lost; no result.
//   Back-to-back: a new frame's first beat may be accepted the cycle after the result handshake.
// TESTING
//   1. Beats 0..9 ascending, s_last on beat 9 -> m_index=9, m_max=0x0009, m_err=0;
//      m_valid exactly 9 cycles after last beat accepted.
//   2. All 0x0100 except idx3=idx7=0x0500 -> m_index=3, m_max=0x0500 (tie to lowest).
//   3. All 0xFF9C (-100) except idx5=0xFFFF (-1), idx0=0x8000 -> m_index=5, m_max=0xFFFF.
//   4. m_ready=0 for 20 cycles in OUT -> m_valid/m_max/m_index/m_err constant, s_ready=0;
//      after handshake s_ready=1 next cycle; a second frame is then accepted correctly.
//   5. Short frame 4,8,2,1 with s_last on beat 3 -> m_index=1, m_max=8, m_err=1, latency 3;
//      10 beats with s_last=0 on beat 9 -> m_err=1, result valid.
//   6. rst_n low during SCAN -> m_valid=0, m_max=0 without a clock edge. clear on beat 4 of a
//      frame -> no result; the following full frame gives the correct argmax and m_err=0.

Source files
------------

// File: rtl/class_argmax_ctrl.sv
// class_argmax_ctrl
// Collects one frame of signed class scores from the FC-output stream.
// Scans the frame with one compare per cycle to find the argmax.
// Presents {max, index, err} on a valid/ready result port.

module class_argmax_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int N_CLASSES  = 10,
  parameter int IDX_WIDTH  = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_max,
  output logic [IDX_WIDTH-1:0]  m_index,
  output logic                  m_err,
  output logic                  busy
);

  localparam logic [IDX_WIDTH-1:0] LAST_BEAT = IDX_WIDTH'(N_CLASSES - 1);
  localparam logic [IDX_WIDTH-1:0] IDX_ZERO  = '0;
  localparam logic [IDX_WIDTH-1:0] IDX_ONE   = IDX_WIDTH'(1);

  typedef enum logic [1:0] {
    COLLECT,
    SCAN,
    OUT
  } state_t;

  state_t                       state;
  logic signed [DATA_WIDTH-1:0] score_mem [N_CLASSES];
  logic [IDX_WIDTH-1:0]         cnt;
  logic [IDX_WIDTH-1:0]         ptr;
  logic [IDX_WIDTH-1:0]         last_idx;
  logic [IDX_WIDTH-1:0]         best_idx;
  logic signed [DATA_WIDTH-1:0] best;

  logic                         beat_ok;
  logic                         frame_end;
  logic signed [DATA_WIDTH-1:0] cand;
  logic                         take_cand;
  logic signed [DATA_WIDTH-1:0] scan_best;
  logic [IDX_WIDTH-1:0]         scan_idx;

  // Beat acceptance, frame termination and the single signed compare of the scan.
  // Strict '>' keeps the earlier index on ties.
  always_comb begin
    beat_ok   = s_valid && s_ready;
    frame_end = s_last || (cnt == LAST_BEAT);
    cand      = score_mem[ptr];
    take_cand = cand > best;
    scan_best = take_cand ? cand : best;
    scan_idx  = take_cand ? ptr : best_idx;
  end

  // Score buffer; contents are don't-care after reset so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == COLLECT && beat_ok && !clear) begin
      score_mem[cnt] <= s_data;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= COLLECT;
      cnt      <= '0;
      ptr      <= '0;
      last_idx <= '0;
      best_idx <= '0;
      best     <= '0;
      s_ready  <= 1'b0;
      m_valid  <= 1'b0;
      m_max    <= '0;
      m_index  <= '0;
      m_err    <= 1'b0;
      busy     <= 1'b0;
    end else if (clear) begin
      state   <= COLLECT;
      cnt     <= '0;
      s_ready <= 1'b1;
      m_valid <= 1'b0;
      m_err   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          s_ready <= 1'b1;
          if (beat_ok) begin
            if (frame_end) begin
              cnt      <= '0;
              last_idx <= cnt;
              best_idx <= '0;
              ptr      <= IDX_ONE;
              m_err    <= !((cnt == LAST_BEAT) && s_last);
              s_ready  <= 1'b0;
              busy     <= 1'b1;
              if (cnt == IDX_ZERO) begin
                best    <= s_data;
                m_max   <= s_data;
                m_index <= '0;
                m_valid <= 1'b1;
                state   <= OUT;
              end else begin
                best  <= score_mem[0];
                state <= SCAN;
              end
            end else begin
              cnt <= cnt + IDX_ONE;
            end
          end
        end

        SCAN: begin
          best     <= scan_best;
          best_idx <= scan_idx;
          if (ptr == last_idx) begin
            m_max   <= scan_best;
            m_index <= scan_idx;
            m_valid <= 1'b1;
            state   <= OUT;
          end else begin
            ptr <= ptr + IDX_ONE;
          end
        end

        OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            m_err   <= 1'b0;
            busy    <= 1'b0;
            s_ready <= 1'b1;
            cnt     <= '0;
            state   <= COLLECT;
          end
        end

        default: begin
          state   <= COLLECT;
          cnt     <= '0;
          m_valid <= 1'b0;
          busy    <= 1'b0;
          s_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_class_argmax_ctrl.sv
// tb_class_argmax_ctrl
// Directed, table-driven bench for class_argmax_ctrl.
// Covers argmax results, ties, signed ordering, short/long frames, back-pressure, clear and async reset.

module tb_class_argmax_ctrl;

  localparam int DW  = 16;
  localparam int NC  = 10;
  localparam int IW  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clear = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_max;
  logic [IW-1:0] m_index;
  logic          m_err;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;

  typedef struct {
    logic [NC-1:0][DW-1:0] data;
    int                    n_beats;
    int                    last_pos;
    logic [DW-1:0]         exp_max;
    logic [IW-1:0]         exp_idx;
    logic                  exp_err;
    int                    exp_lat;
  } vec_t;

  vec_t vecs [7];

  class_argmax_ctrl #(
    .DATA_WIDTH(DW),
    .N_CLASSES (NC),
    .IDX_WIDTH (IW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .s_last (s_last),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_max  (m_max),
    .m_index(m_index),
    .m_err  (m_err),
    .busy   (busy)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Cycle counter used for latency measurement
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    int guard;
    guard   = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!s_ready) checkOutput("s_ready_wait", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic applyStimulus(input int vi);
    for (int b = 0; b < vecs[vi].n_beats; b++) begin
      send_beat(vecs[vi].data[b], (b == vecs[vi].last_pos));
    end
    acc_cyc = cyc;
  endtask

  task automatic wait_result(output int lat);
    int guard;
    guard = 0;
    while (!m_valid && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!m_valid) checkOutput("m_valid_timeout", 32'(m_valid), 32'd1);
    lat = cyc - acc_cyc;
  endtask

  task automatic handshake();
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    checkOutput("post_hs_m_valid", 32'(m_valid), 32'd0);
    checkOutput("post_hs_s_ready", 32'(s_ready), 32'd1);
  endtask

  task automatic run_vector(input int vi, input int stall);
    int lat;
    applyStimulus(vi);
    checkOutput($sformatf("v%0d_busy", vi), 32'(busy), 32'd1);
    checkOutput($sformatf("v%0d_s_ready_low", vi), 32'(s_ready), 32'd0);
    wait_result(lat);
    checkOutput($sformatf("v%0d_max", vi), 32'(m_max), 32'(vecs[vi].exp_max));
    checkOutput($sformatf("v%0d_idx", vi), 32'(m_index), 32'(vecs[vi].exp_idx));
    checkOutput($sformatf("v%0d_err", vi), 32'(m_err), 32'(vecs[vi].exp_err));
    checkOutput($sformatf("v%0d_latency", vi), 32'(lat), 32'(vecs[vi].exp_lat));
    for (int c = 0; c < stall; c++) begin
      @(posedge clk); #1;
      checkOutput("stall_m_valid", 32'(m_valid), 32'd1);
      checkOutput("stall_m_max", 32'(m_max), 32'(vecs[vi].exp_max));
      checkOutput("stall_m_index", 32'(m_index), 32'(vecs[vi].exp_idx));
      checkOutput("stall_m_err", 32'(m_err), 32'(vecs[vi].exp_err));
      checkOutput("stall_s_ready", 32'(s_ready), 32'd0);
    end
    handshake();
  endtask

  task automatic watch_no_result(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (m_valid) seen++;
    end
    checkOutput(name, 32'(seen), 32'd0);
  endtask

  // Stimulus and checking sequence
  initial begin
    // Ascending 0..9, s_last on beat 9
    for (int i = 0; i < NC; i++) vecs[0].data[i] = DW'(i);
    vecs[0].n_beats = 10; vecs[0].last_pos = 9;
    vecs[0].exp_max = 16'h0009; vecs[0].exp_idx = 4'd9; vecs[0].exp_err = 1'b0; vecs[0].exp_lat = 9;
    // Tie between idx3 and idx7 resolves to 3
    for (int i = 0; i < NC; i++) vecs[1].data[i] = 16'h0100;
    vecs[1].data[3] = 16'h0500; vecs[1].data[7] = 16'h0500;
    vecs[1].n_beats = 10; vecs[1].last_pos = 9;
    vecs[1].exp_max = 16'h0500; vecs[1].exp_idx = 4'd3; vecs[1].exp_err = 1'b0; vecs[1].exp_lat = 9;
    // All negative; -1 is the maximum, 0x8000 the most negative
    for (int i = 0; i < NC; i++) vecs[2].data[i] = 16'hFF9C;
    vecs[2].data[5] = 16'hFFFF; vecs[2].data[0] = 16'h8000;
    vecs[2].n_beats = 10; vecs[2].last_pos = 9;
    vecs[2].exp_max = 16'hFFFF; vecs[2].exp_idx = 4'd5; vecs[2].exp_err = 1'b0; vecs[2].exp_lat = 9;
    // Short frame of 4
    vecs[3].data = '0;
    vecs[3].data[0] = 16'd4; vecs[3].data[1] = 16'd8; vecs[3].data[2] = 16'd2; vecs[3].data[3] = 16'd1;
    vecs[3].n_beats = 4; vecs[3].last_pos = 3;
    vecs[3].exp_max = 16'd8; vecs[3].exp_idx = 4'd1; vecs[3].exp_err = 1'b1; vecs[3].exp_lat = 3;
    // Full length without s_last
    vecs[4].data[0] = 16'd3; vecs[4].data[1] = 16'd1; vecs[4].data[2] = 16'd4; vecs[4].data[3] = 16'd1;
    vecs[4].data[4] = 16'd5; vecs[4].data[5] = 16'd9; vecs[4].data[6] = 16'd2; vecs[4].data[7] = 16'd6;
    vecs[4].data[8] = 16'd5; vecs[4].data[9] = 16'd3;
    vecs[4].n_beats = 10; vecs[4].last_pos = -1;
    vecs[4].exp_max = 16'd9; vecs[4].exp_idx = 4'd5; vecs[4].exp_err = 1'b1; vecs[4].exp_lat = 9;
    // Single-beat frame goes straight to the result
    vecs[5].data = '0; vecs[5].data[0] = 16'h1234;
    vecs[5].n_beats = 1; vecs[5].last_pos = 0;
    vecs[5].exp_max = 16'h1234; vecs[5].exp_idx = 4'd0; vecs[5].exp_err = 1'b1; vecs[5].exp_lat = 0;
    // Positive full-scale at both ends; first one wins
    for (int i = 0; i < NC; i++) vecs[6].data[i] = 16'h7FFE;
    vecs[6].data[0] = 16'h7FFF; vecs[6].data[9] = 16'h7FFF;
    vecs[6].n_beats = 10; vecs[6].last_pos = 9;
    vecs[6].exp_max = 16'h7FFF; vecs[6].exp_idx = 4'd0; vecs[6].exp_err = 1'b0; vecs[6].exp_lat = 9;

    // Asynchronous reset and reset-state checks
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
    checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_m_max", 32'(m_max), 32'd0);
    checkOutput("rst_m_index", 32'(m_index), 32'd0);
    checkOutput("rst_m_err", 32'(m_err), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Table-driven frames, back to back
    for (int v = 0; v < 7; v++) begin
      run_vector(v, 0);
    end

    // Result held under back-pressure, then a second frame
    $display("[TB] back-pressure sequence");
    run_vector(1, 20);
    run_vector(4, 0);

    // clear on beat 4 drops the frame; the next frame is unaffected
    $display("[TB] clear mid-frame sequence");
    for (int b = 0; b < 4; b++) send_beat(vecs[1].data[b], 1'b0);
    s_valid = 1'b1; s_data = 16'h7FFF; s_last = 1'b0; clear = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; clear = 1'b0;
    checkOutput("clear_s_ready", 32'(s_ready), 32'd1);
    checkOutput("clear_busy", 32'(busy), 32'd0);
    watch_no_result("clear_no_result", 12);
    run_vector(2, 0);

    // clear while a result is pending
    $display("[TB] clear in result state");
    begin
      int lat;
      applyStimulus(3);
      wait_result(lat);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      checkOutput("clear_out_m_valid", 32'(m_valid), 32'd0);
      checkOutput("clear_out_m_err", 32'(m_err), 32'd0);
      checkOutput("clear_out_s_ready", 32'(s_ready), 32'd1);
    end
    run_vector(0, 0);

    // Async reset during the scan clears outputs without a clock edge
    $display("[TB] reset during scan");
    applyStimulus(1);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("scan_rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("scan_rst_m_max", 32'(m_max), 32'd0);
    checkOutput("scan_rst_m_index", 32'(m_index), 32'd0);
    checkOutput("scan_rst_busy", 32'(busy), 32'd0);
    checkOutput("scan_rst_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    watch_no_result("scan_rst_no_result", 12);
    run_vector(6, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
